// File: rtl/regfile_mp_if.sv
// Register-file port bundle: two write ports, NR packed read ports and the clear-engine busy flag.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NR    = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]          we;
  logic [2*AW-1:0]     wa;
  logic [2*WIDTH-1:0]  wd;
  logic [NR*AW-1:0]    ra;
  logic [NR*WIDTH-1:0] rd;
  logic                busy;

  modport master (output we, wa, wd, ra, input rd, busy);
  modport slave  (input we, wa, wd, ra, output rd, busy);
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational reads, two clocked writes, sequential clear after reset.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int  WIDTH    = 32,
  parameter int  DEPTH    = 32,
  parameter int  NR       = 2,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave rf
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_busy;
  logic [1:0]       w_wen;
  logic [AW-1:0]    w_wa [2];
  logic [WIDTH-1:0] w_wd [2];

  genvar gi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // The index wraps to 0 on its own because DEPTH is a power of two.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      CLEAR: begin
        w_idx_next = r_idx + AW'(1);
        if (r_idx == AW'(DEPTH - 1)) begin
          w_state_next = READY;
        end
      end
      READY: w_idx_next = '0;
    endcase
  end

  assign w_busy  = (r_state == CLEAR);
  assign rf.busy = w_busy;

  for (gi = 0; gi < 2; gi++) begin : g_wport
    assign w_wa[gi]  = rf.wa[gi*AW +: AW];
    assign w_wd[gi]  = rf.wd[gi*WIDTH +: WIDTH];
    assign w_wen[gi] = rf.we[gi] && !w_busy && !((ZERO_REG != 0) && (w_wa[gi] == '0));
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_busy) begin
        r_mem[r_idx] <= '0;
      end else begin
        if (w_wen[0]) r_mem[w_wa[0]] <= w_wd[0];
        if (w_wen[1]) r_mem[w_wa[1]] <= w_wd[1];
      end
    end
  end

  for (gi = 0; gi < NR; gi++) begin : g_rport
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_rd;

    assign w_ra = rf.ra[gi*AW +: AW];

    always_comb begin
      w_rd = r_mem[w_ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (w_wen[0] && (w_wa[0] == w_ra)) w_rd = w_wd[0];
      if (w_wen[1] && (w_wa[1] == w_ra)) w_rd = w_wd[1];
`endif
      if (w_busy || ((ZERO_REG != 0) && (w_ra == '0))) w_rd = '0;
    end

    assign rf.rd[gi*WIDTH +: WIDTH] = w_rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two DUTs (ZERO_REG=0 and ZERO_REG=1) share stimulus and are compared
// against an array-based reference model updated once per clock edge.
`timescale 1ns/1ps
module tb_regfile_mp;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int AW    = $clog2(DEPTH);

  logic                clk   = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          we    = '0;
  logic [2*AW-1:0]     wa    = '0;
  logic [2*WIDTH-1:0]  wd    = '0;
  logic [NR*AW-1:0]    ra    = '0;
  logic [NR*WIDTH-1:0] rd_z0;
  logic [NR*WIDTH-1:0] rd_z1;
  logic                busy_z0;
  logic                busy_z1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR)) if_z0 ();
  regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR)) if_z1 ();

  assign if_z0.we = we;
  assign if_z0.wa = wa;
  assign if_z0.wd = wd;
  assign if_z0.ra = ra;
  assign if_z1.we = we;
  assign if_z1.wa = wa;
  assign if_z1.wd = wd;
  assign if_z1.ra = ra;
  assign rd_z0    = if_z0.rd;
  assign rd_z1    = if_z1.rd;
  assign busy_z0  = if_z0.busy;
  assign busy_z1  = if_z1.busy;

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .reset(reset), .rf(if_z0)
  );
  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .ZERO_REG(1)) dut_z1 (
    .clk(clk), .reset(reset), .rf(if_z1)
  );

  // Reference model: index 0 models ZERO_REG=0, index 1 models ZERO_REG=1.
  logic [WIDTH-1:0] m [2][DEPTH];
  int clear_left = DEPTH;

  function automatic logic [AW-1:0] get_wa(int k);
    return wa[k*AW +: AW];
  endfunction

  function automatic logic [WIDTH-1:0] get_wd(int k);
    return wd[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic exp_busy();
    return clear_left > 0;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(int z, int j);
    logic [AW-1:0] a;
    a = ra[j*AW +: AW];
    if (clear_left > 0) return '0;
    if (z == 1 && a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
    for (int k = 1; k >= 0; k--) begin
      if (we[k] && get_wa(k) == a && !(z == 1 && a == 0)) return get_wd(k);
    end
`endif
    return m[z][a];
  endfunction

  function automatic logic [WIDTH-1:0] dut_rd(int z, int j);
    return (z == 0) ? rd_z0[j*WIDTH +: WIDTH] : rd_z1[j*WIDTH +: WIDTH];
  endfunction

  function automatic logic dut_busy(int z);
    return (z == 0) ? busy_z0 : busy_z1;
  endfunction

  task automatic model_edge();
    if (reset) begin
      clear_left = DEPTH;
      for (int z = 0; z < 2; z++)
        for (int a = 0; a < DEPTH; a++) m[z][a] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      for (int k = 0; k < 2; k++)
        if (we[k])
          for (int z = 0; z < 2; z++)
            if (!(z == 1 && get_wa(k) == 0)) m[z][get_wa(k)] = get_wd(k);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    we    = '0;
    ra    = AW'(5);
    cycle();
    reset = 1'b0;
    for (int i = 0; i <= DEPTH + 2; i++) begin
      ra = NR*AW'($urandom);
      #1;
      for (int z = 0; z < 2; z++) begin
        n_checks++;
        if (dut_busy(z) !== exp_busy()) begin
          n_errors++;
          $display("FAIL reset_busy z%0d cyc%0d: got %b exp %b", z, i, dut_busy(z), exp_busy());
        end
        for (int j = 0; j < NR; j++) begin
          n_checks++;
          if (dut_rd(z, j) !== exp_rd(z, j)) begin
            n_errors++;
            $display("FAIL reset_rd z%0d p%0d cyc%0d: got %h exp %h", z, j, i, dut_rd(z, j), exp_rd(z, j));
          end
        end
      end
      cycle();
    end
  endtask

  // Drives one write pattern, checks the same cycle and the following one.
  task automatic test_write(string name, logic [1:0] w_en, int a0, int a1,
                            logic [WIDTH-1:0] d0, logic [WIDTH-1:0] d1, int r0, int r1);
    we = w_en;
    wa[0 +: AW]     = AW'(a0);
    wa[AW +: AW]    = AW'(a1);
    wd[0 +: WIDTH]  = d0;
    wd[WIDTH +: WIDTH] = d1;
    ra[0 +: AW]     = AW'(r0);
    ra[AW +: AW]    = AW'(r1);
    for (int ph = 0; ph < 2; ph++) begin
      #1;
      for (int z = 0; z < 2; z++)
        for (int j = 0; j < NR; j++) begin
          n_checks++;
          if (dut_rd(z, j) !== exp_rd(z, j)) begin
            n_errors++;
            $display("FAIL %s z%0d p%0d ph%0d: got %h exp %h", name, z, j, ph, dut_rd(z, j), exp_rd(z, j));
          end
        end
      cycle();
      we = '0;
    end
  endtask

  task automatic test_reset_midclear();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i <= DEPTH + 1; i++) begin
      we = (i == 5) ? 2'b11 : 2'b00;
      wa = {AW'(12), AW'(9)};
      wd = {32'h1234_5678, 32'hABCD_0009};
      ra = {AW'(12), AW'(9)};
      #1;
      for (int z = 0; z < 2; z++) begin
        n_checks++;
        if (dut_busy(z) !== exp_busy()) begin
          n_errors++;
          $display("FAIL midclear_busy z%0d cyc%0d: got %b exp %b", z, i, dut_busy(z), exp_busy());
        end
        for (int j = 0; j < NR; j++) begin
          n_checks++;
          if (dut_rd(z, j) !== exp_rd(z, j)) begin
            n_errors++;
            $display("FAIL midclear_rd z%0d p%0d cyc%0d: got %h exp %h", z, j, i, dut_rd(z, j), exp_rd(z, j));
          end
        end
      end
      cycle();
    end
    we = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      we = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        wa[k*AW +: AW]       = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        wd[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      for (int j = 0; j < NR; j++)
        ra[j*AW +: AW] = ($urandom_range(0, 2) == 0) ? get_wa($urandom_range(0, 1)) : AW'($urandom_range(0, 7));
      #1;
      for (int z = 0; z < 2; z++)
        for (int j = 0; j < NR; j++) begin
          n_checks++;
          if (dut_rd(z, j) !== exp_rd(z, j)) begin
            n_errors++;
            $display("FAIL random z%0d p%0d it%0d: got %h exp %h", z, j, i, dut_rd(z, j), exp_rd(z, j));
          end
        end
      cycle();
    end
    we = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write("basic",     2'b01, 5, 0, 32'hDEAD_BEEF, 32'h0,         5, 0);
    test_write("same_addr", 2'b11, 7, 7, 32'h1111_1111, 32'h2222_2222, 7, 7);
    test_write("zero_reg",  2'b01, 0, 0, 32'hFFFF_FFFF, 32'h0,         0, 0);
    test_write("bypass",    2'b01, 3, 0, 32'hCAFE_0003, 32'h0,         3, 5);
    test_reset_midclear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
